// File: rtl/antidroop_seq_ctrl.sv
// Per-pulse sequencer and configuration controller for the anti-droop IIR stage.
// Synchronizes the beam trigger, steps IDLE/ARMED/CLEAR/ACTIVE, defers host
// tap-weight updates to pulse boundaries and counts IIR overflow inside the
// measurement window.
// Optional build macro: ANTIDROOP_AUTO_BACKOFF_EN halves the active weight after
// any pulse whose window saw an overflow-count increment.
module antidroop_seq_ctrl #(
   parameter int WIN_LEN  = 164,
   parameter int CNT_W    = 16,
   parameter int WEIGHT_W = 7
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       enable,
   input  logic                       trig,
   input  logic                       cfg_acc_clr,
   input  logic signed [WEIGHT_W-1:0] cfg_weight,
   input  logic                       cfg_valid,
   output logic                       cfg_ready,
   input  logic                       oflow_clr,
   input  logic                       iir_oflow,
   output logic                       iir_trig,
   output logic                       iir_accClr_en,
   output logic signed [WEIGHT_W-1:0] iir_tapWeight,
   output logic                       window,
   output logic                       oflow_sticky,
   output logic [CNT_W-1:0]           oflow_cnt,
   output logic [CNT_W-1:0]           pulse_cnt,
   output logic                       trig_missed
);

   typedef enum logic [1:0] {IDLE, ARMED, CLEAR, ACTIVE} state_t;

   localparam int            CW       = $clog2(WIN_LEN + 2);
   localparam logic [CW-1:0] LAST_ACT = CW'(WIN_LEN - 1);

   state_t                       state, state_nx;
   logic [CW-1:0]                phase_cnt;
   logic                         trig_p0, trig_p1, trig_p2;
   logic                         trig_rise;
   logic                         enter_clear, pulse_end;
   logic                         oflow_hit, oflow_step;
   logic                         xfer, commit;
   logic                         shadow_full;
   logic signed [WEIGHT_W-1:0]   shadow;

   assign trig_rise  = trig_p1 & ~trig_p2;
   assign oflow_hit  = (state == ACTIVE) && iir_oflow;
   assign oflow_step = oflow_hit && !oflow_clr && (oflow_cnt != '1);
   assign xfer       = cfg_valid & cfg_ready;
   assign commit     = shadow_full && ((state == IDLE) || enter_clear);

   // Trigger synchronizer (p0/p1) followed by the edge-detect register (p2)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trig_p0 <= 1'b0;
         trig_p1 <= 1'b0;
         trig_p2 <= 1'b0;
      end else begin
         trig_p0 <= trig;
         trig_p1 <= trig_p0;
         trig_p2 <= trig_p1;
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state logic; losing enable overrides every other transition
   always_comb begin
      state_nx    = state;
      enter_clear = 1'b0;
      pulse_end   = 1'b0;
      case (state)
         IDLE:    if (enable) state_nx = ARMED;
         ARMED:   if (trig_rise) state_nx = CLEAR;
         CLEAR:   if (phase_cnt == CW'(1)) state_nx = ACTIVE;
         ACTIVE:  if (phase_cnt == LAST_ACT) state_nx = ARMED;
         default: state_nx = IDLE;
      endcase
      if (!enable) state_nx = IDLE;
      enter_clear = (state == ARMED)  && (state_nx == CLEAR);
      pulse_end   = (state == ACTIVE) && (state_nx == ARMED);
   end

   // Cycle counter for the CLEAR and ACTIVE phases, restarted on every transition
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                     phase_cnt <= '0;
      else if (state_nx != state)                     phase_cnt <= '0;
      else if ((state == CLEAR) || (state == ACTIVE)) phase_cnt <= phase_cnt + CW'(1);
   end

   // Registered IIR strobes, window flag, accumulator-clear copy and pulse counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         iir_trig      <= 1'b0;
         window        <= 1'b0;
         iir_accClr_en <= 1'b0;
         pulse_cnt     <= '0;
      end else begin
         iir_trig <= (state_nx == CLEAR);
         window   <= (state_nx == ACTIVE);
         if ((state == IDLE) || (state == ARMED)) iir_accClr_en <= cfg_acc_clr;
         if (enter_clear) pulse_cnt <= pulse_cnt + CNT_W'(1);
      end
   end

   // Overflow monitor and missed-trigger flag; host clear beats a same-cycle set
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         oflow_cnt    <= '0;
         oflow_sticky <= 1'b0;
         trig_missed  <= 1'b0;
      end else if (oflow_clr) begin
         oflow_cnt    <= '0;
         oflow_sticky <= 1'b0;
         trig_missed  <= 1'b0;
      end else begin
         if (oflow_step) oflow_cnt <= oflow_cnt + CNT_W'(1);
         if (oflow_hit) oflow_sticky <= 1'b1;
         if (trig_rise && (state != ARMED)) trig_missed <= 1'b1;
      end
   end

   // Shadow data register; only loaded on a handshake so it needs no reset
   always_ff @(posedge clk) begin
      if (xfer) shadow <= cfg_weight;
   end

   // Handshake control: ready falls on capture and returns one cycle after commit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_full <= 1'b0;
         cfg_ready   <= 1'b0;
      end else begin
         if (xfer)        shadow_full <= 1'b1;
         else if (commit) shadow_full <= 1'b0;
         cfg_ready <= xfer ? 1'b0 : ~shadow_full;
      end
   end

`ifdef ANTIDROOP_AUTO_BACKOFF_EN
   logic pulse_inc;

   function automatic logic signed [WEIGHT_W-1:0] backoff(input logic signed [WEIGHT_W-1:0] w);
      logic signed [WEIGHT_W-1:0] s;
      s = w >>> 1;
      if (&s) s = '0;
      return s;
   endfunction

   // Remembers whether the current pulse incremented the overflow count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          pulse_inc <= 1'b0;
      else if (enter_clear) pulse_inc <= 1'b0;
      else if (oflow_step)  pulse_inc <= 1'b1;
   end

   // Active weight: pending shadow commits, otherwise halve after an overflowing pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                  iir_tapWeight <= '0;
      else if (commit)                             iir_tapWeight <= shadow;
      else if (pulse_end && (pulse_inc || oflow_step)) iir_tapWeight <= backoff(iir_tapWeight);
   end
`else
   // Active weight changes only through a shadow commit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      iir_tapWeight <= '0;
      else if (commit) iir_tapWeight <= shadow;
   end
`endif

endmodule

// File: tb/tb_antidroop_seq_ctrl.sv
// Self-checking bench for antidroop_seq_ctrl: directed pulse scenarios with
// randomized overflow, accumulator-clear and weight traffic, compared every
// cycle against a phase-timeline reference model.
module tb_antidroop_seq_ctrl;

   localparam int WL   = 164;
   localparam int CW   = 4;
   localparam int WW   = 7;
   localparam int P_IDLE = 0, P_ARM = 1, P_CLR = 2, P_ACT = 3;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 enable, trig, cfg_acc_clr, cfg_valid, oflow_clr, iir_oflow;
   logic signed [WW-1:0] cfg_weight;
   logic                 cfg_ready, iir_trig, iir_accClr_en, window, oflow_sticky, trig_missed;
   logic signed [WW-1:0] iir_tapWeight;
   logic [CW-1:0]        oflow_cnt, pulse_cnt;

   antidroop_seq_ctrl #(.WIN_LEN(WL), .CNT_W(CW), .WEIGHT_W(WW)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .trig(trig),
      .cfg_acc_clr(cfg_acc_clr), .cfg_weight(cfg_weight), .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready), .oflow_clr(oflow_clr), .iir_oflow(iir_oflow),
      .iir_trig(iir_trig), .iir_accClr_en(iir_accClr_en), .iir_tapWeight(iir_tapWeight),
      .window(window), .oflow_sticky(oflow_sticky), .oflow_cnt(oflow_cnt),
      .pulse_cnt(pulse_cnt), .trig_missed(trig_missed)
   );

   always #5 clk = ~clk;

   int checks = 0, passes = 0, fails = 0, cyc = 0, rdy_at = -1;

   // reference model state
   logic [CW-1:0]        e_pulse = '0, e_cnt = '0;
   bit                   e_sticky, e_missed, e_ready, e_trig, e_win, e_acc;
   logic signed [WW-1:0] e_tap = '0, pend_val = '0;
   bit                   pending, inc_seen;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic chk_all();
      chk("iir_trig",     32'(iir_trig),      32'(e_trig));
      chk("window",       32'(window),        32'(e_win));
      chk("pulse_cnt",    32'(pulse_cnt),     32'(e_pulse));
      chk("oflow_cnt",    32'(oflow_cnt),     32'(e_cnt));
      chk("oflow_sticky", 32'(oflow_sticky),  32'(e_sticky));
      chk("trig_missed",  32'(trig_missed),   32'(e_missed));
      chk("cfg_ready",    32'(cfg_ready),     32'(e_ready));
      chk("tapWeight",    32'(iir_tapWeight), 32'(e_tap));
      chk("accClr_en",    32'(iir_accClr_en), 32'(e_acc));
   endtask

   function automatic logic signed [WW-1:0] halve(input logic signed [WW-1:0] w);
      logic signed [WW-1:0] r;
      r = w >>> 1;
      if (r == -1) r = 0;
      return r;
   endfunction

   // Pulse phase after edge e counted from the edge that first samples trig high
   function automatic int ph(input int e, input int dis);
      if (dis >= 0 && e >= dis + 1) return P_IDLE;
      if (e < 2)      return P_ARM;
      if (e < 4)      return P_CLR;
      if (e < 4 + WL) return P_ACT;
      return P_ARM;
   endfunction

   // Apply the rules for one clock edge given phase before (pb) and after (pa)
   task automatic model_edge(input int pb, input int pa, input bit miss_set);
      bit cap;
      cap = cfg_valid && e_ready;
      if (pb == P_IDLE || pb == P_ARM) e_acc = cfg_acc_clr;
      if (pb == P_ACT && iir_oflow) begin
         if (e_cnt != '1) begin
            e_cnt = e_cnt + 1'b1;
            if (!oflow_clr) inc_seen = 1;
         end
         e_sticky = 1;
      end
      if (miss_set) e_missed = 1;
      if (oflow_clr) begin
         e_cnt = '0; e_sticky = 0; e_missed = 0;
      end
      if (pb == P_ARM && pa == P_CLR) begin
         e_pulse = e_pulse + 1'b1;
         inc_seen = 0;
      end
`ifdef ANTIDROOP_AUTO_BACKOFF_EN
      if (pb == P_ACT && pa == P_ARM && inc_seen) e_tap = halve(e_tap);
`endif
      if (pending && (pb == P_IDLE || (pb == P_ARM && pa == P_CLR))) begin
         e_tap = pend_val; pending = 0; rdy_at = cyc + 1;
      end
      if (cyc == rdy_at) e_ready = 1;
      if (cap) begin
         pending = 1; pend_val = cfg_weight; e_ready = 0;
      end
      e_trig = (pa == P_CLR);
      e_win  = (pa == P_ACT);
   endtask

   // Quiet cycles in a fixed phase, with optional one-cycle trig pulse and weight write
   task automatic wait_cycles(input int n, input int phb, input int trig_at,
                              input int wr_at, input logic signed [WW-1:0] wv);
      for (int i = 0; i < n; i++) begin
         tick();
         model_edge(phb, phb, trig_at >= 0 && i == trig_at + 3 && phb != P_ARM);
         chk_all();
         trig        = (i == trig_at);
         iir_oflow   = ($urandom_range(0, 3) == 0);
         cfg_acc_clr = 1'($urandom_range(0, 1));
         oflow_clr   = 1'b0;
         cfg_valid   = (i == wr_at);
         cfg_weight  = (i == wr_at) ? wv : WW'($urandom);
      end
      trig = 1'b0; cfg_valid = 1'b0;
   endtask

   // One trigger-started pulse followed by a few ARMED cycles
   task automatic run_pulse(input int dis_at, input int wr_at, input logic signed [WW-1:0] wv,
                            input bit trig2, input int clr_at, input int force_of);
      int pb, pa;
      trig = 1'b1;
      for (int d = 0; d <= WL + 7; d++) begin
         tick();
         pb = ph(d - 1, dis_at);
         pa = ph(d, dis_at);
         model_edge(pb, pa, trig2 && d == 23 && pb != P_ARM);
         chk_all();
         if (d == 5 || d == 30) trig = 1'b0;
         if (trig2 && d == 20)  trig = 1'b1;
         iir_oflow   = ($urandom_range(0, 15) == 0) || d == force_of || d == clr_at;
         oflow_clr   = (d == clr_at);
         cfg_acc_clr = 1'($urandom_range(0, 1));
         cfg_valid   = (wr_at >= 0) && (d >= wr_at) && (d <= wr_at + 5);
         cfg_weight  = (d == wr_at) ? wv : WW'($urandom);
         if (d == dis_at) enable = 1'b0;
      end
      iir_oflow = 1'b0; oflow_clr = 1'b0; cfg_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b0; trig = 1'b0; cfg_acc_clr = 1'b0;
      cfg_valid = 1'b0; cfg_weight = '0; oflow_clr = 1'b0; iir_oflow = 1'b0;

      // reset held with toggling inputs: every output stays 0
      for (int i = 0; i < 6; i++) begin
         tick();
         chk_all();
         enable      = 1'($urandom_range(0, 1));
         trig        = 1'($urandom_range(0, 1));
         cfg_acc_clr = 1'($urandom_range(0, 1));
         cfg_valid   = 1'($urandom_range(0, 1));
         cfg_weight  = WW'($urandom);
         oflow_clr   = 1'($urandom_range(0, 1));
         iir_oflow   = 1'($urandom_range(0, 1));
      end

      // release with enable low: ready rises, no trigger activity
      rst_n = 1'b1; enable = 1'b0; trig = 1'b0; cfg_valid = 1'b0; oflow_clr = 1'b0;
      rdy_at = cyc + 1;
      wait_cycles(4, P_IDLE, -1, -1, '0);

      // IDLE weight write commits the cycle after capture
      wait_cycles(6, P_IDLE, -1, 1, WW'($urandom));

      // trigger edge while IDLE marks a missed trigger
      wait_cycles(10, P_IDLE, 2, -1, '0);

      enable = 1'b1;
      wait_cycles(1, P_IDLE, -1, -1, '0);
      wait_cycles(3, P_ARM, -1, -1, '0);

      // nominal pulse; weight 63 written during ACTIVE; clear coincident with an overflow
      run_pulse(-1, 50, 7'sd63, 1'b0, 30, -1);
      wait_cycles(3, P_ARM, -1, -1, '0);

      // 63 commits at CLEAR entry; second trigger during ACTIVE is only flagged
      run_pulse(-1, -1, '0, 1'b1, -1, -1);
      wait_cycles(2, P_ARM, -1, -1, '0);

      // disable mid-ACTIVE: window/trig drop, counters held
      run_pulse(60, -1, '0, 1'b0, -1, -1);
      wait_cycles(4, P_IDLE, -1, -1, '0);
      enable = 1'b1;
      wait_cycles(1, P_IDLE, -1, -1, '0);
      wait_cycles(2, P_ARM, -1, -1, '0);

      // randomized pulses, enough to wrap pulse_cnt and saturate oflow_cnt
      for (int k = 0; k < 14; k++) begin
         run_pulse(-1,
                   ($urandom_range(0, 1) == 1) ? int'($urandom_range(10, 150)) : -1,
                   WW'($urandom), 1'b0,
                   ($urandom_range(0, 2) == 0) ? int'($urandom_range(8, 160)) : -1, -1);
         wait_cycles(2, P_ARM, -1, -1, '0);
      end

`ifdef ANTIDROOP_AUTO_BACKOFF_EN
      // back-off: -64 -> -32, -1 -> 0, pending 20 overrides at the next CLEAR
      run_pulse(-1, 50, -7'sd64, 1'b0, 5, -1);
      wait_cycles(2, P_ARM, -1, -1, '0);
      run_pulse(-1, 50, -7'sd1, 1'b0, 8, 10);
      wait_cycles(2, P_ARM, -1, -1, '0);
      run_pulse(-1, 50, 7'sd20, 1'b0, 8, 10);
      wait_cycles(2, P_ARM, -1, -1, '0);
      run_pulse(-1, -1, '0, 1'b0, 8, 10);
      wait_cycles(2, P_ARM, -1, -1, '0);
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/antidroop_seq_ctrl.md
Name: antidroop_seq_ctrl

Overview:
- Per-pulse sequencer and configuration controller for the 16-bit anti-droop IIR correction stage.
- Detects the beam trigger and issues the IIR trigger/accumulator-clear.
- Applies host tap-weight updates only between pulses, so a pulse never sees a weight change.
- Counts IIR overflow cycles inside a fixed measurement window; sits between the host register bank and the IIR instance.

Parameters:
- WIN_LEN, 164, ACTIVE window length in clk cycles (must be ≥1).
- CNT_W, 16, width of the overflow and pulse counters.
- WEIGHT_W, 7, signed tap-weight width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  sequencer enable (level)
- trig  in  1  asynchronous beam trigger (level)
- cfg_acc_clr  in  1  host request: clear the IIR accumulator on each trigger
- cfg_weight  in  WEIGHT_W  signed new tap weight
- cfg_valid  in  1  cfg_weight valid
- cfg_ready  out  1  shadow register free
- oflow_clr  in  1  clear sticky flags and overflow count
- iir_oflow  in  1  overflow flag from the IIR
- iir_trig  out  1  trigger to the IIR
- iir_accClr_en  out  1  accumulator-clear enable to the IIR
- iir_tapWeight  out  WEIGHT_W  signed active weight to the IIR
- window  out  1  high during ACTIVE
- oflow_sticky  out  1  overflow seen since the last clear
- oflow_cnt  out  CNT_W  ACTIVE cycles with iir_oflow=1, saturating
- pulse_cnt  out  CNT_W  pulses sequenced, wrapping
- trig_missed  out  1  sticky: trigger edge arrived outside ARMED

Behaviour:
- Reset: every output register is 0, including iir_tapWeight and cfg_ready. The FSM is in IDLE and the shadow register is empty. cfg_ready rises the first cycle after reset release.
- Trigger path: trig passes through a 2-flop synchronizer and then an edge register. A rising edge sampled at edge N is seen by the FSM at edge N+2.
- FSM states: IDLE, ARMED, CLEAR, ACTIVE.
  - IDLE → ARMED when enable=1.
  - ARMED → CLEAR on a synchronized trig rising edge.
  - CLEAR lasts exactly 2 cycles, then → ACTIVE.
  - ACTIVE lasts WIN_LEN cycles, then → ARMED.
  - Any state → IDLE on the cycle after enable=0. Leaving mid-pulse forces iir_trig=0 and window=0; counters are held.
- iir_trig is registered; it is high exactly in the 2 CLEAR cycles. window is high exactly in the ACTIVE cycles.
- iir_accClr_en is a registered copy of cfg_acc_clr. It updates only in IDLE/ARMED and is frozen during CLEAR/ACTIVE.
- Weight handshake:
  - A transfer occurs when cfg_valid=1 and cfg_ready=1; the value is captured into the shadow and cfg_ready drops next cycle.
  - The shadow commits to iir_tapWeight on the edge entering CLEAR, the same edge iir_trig rises.
  - In IDLE the shadow commits on the cycle after capture.
  - cfg_ready reasserts the cycle after commit.
  - iir_tapWeight never changes during CLEAR or ACTIVE.
- pulse_cnt increments on entry to CLEAR and wraps from all-ones to 0.
- Overflow monitoring (ACTIVE only):
  - iir_oflow=1 increments oflow_cnt, saturating at all-ones, and sets oflow_sticky.
  - iir_oflow is ignored in all other states.
- A synchronized trig edge in CLEAR, ACTIVE or IDLE sets trig_missed; the edge is otherwise ignored, with no restart.
- oflow_clr clears oflow_sticky, oflow_cnt and trig_missed. If oflow_clr coincides with a set or increment in the same cycle, the clear wins and the count is 0.
- Counters and flags do not reset on enable=0; only rst_n or oflow_clr clears them.

Optional Feature:
- Macro: ANTIDROOP_AUTO_BACKOFF_EN.
- When defined, at the ACTIVE→ARMED transition of a pulse during which oflow_cnt incremented:
  - iir_tapWeight <= iir_tapWeight >>> 1 (arithmetic shift).
  - A result of -1 is forced to 0.
  - If the shadow holds a pending weight, it still commits at the next CLEAR and overrides the back-off.
- When undefined: iir_tapWeight changes only via the handshake.

Test Plan:
- Reset/idle: rst_n=0 with all inputs toggling → all outputs 0. After release with enable=0, cfg_ready=1 and iir_trig never rises.
- Nominal pulse, WIN_LEN=164: enable=1, trig rises at edge 10 → iir_trig high at edges 13–14, window high at edges 15–178, back in ARMED at edge 179, pulse_cnt=1.
- Weight deferral: ARMED with iir_tapWeight=0; write cfg_weight=63 during ACTIVE → iir_tapWeight stays 0 until the next CLEAR entry, then becomes 63. cfg_ready low from capture until the cycle after commit.
- Overflow: iir_oflow high for 5 ACTIVE cycles and 3 ARMED cycles → oflow_cnt=5, oflow_sticky=1. oflow_clr pulsed in the same cycle as an oflow increment → oflow_cnt=0, oflow_sticky=0.
- Missed trigger and mid-pulse disable: second trig edge during ACTIVE → trig_missed=1, pulse_cnt unchanged. enable=0 mid-ACTIVE → window=0 and iir_trig=0 next cycle, FSM in IDLE.
- Back-off (macro defined): weight -64, overflow during a pulse → -32 after the pulse; starting from -1 → 0; pending shadow 20 → 20 at next CLEAR.
